// File: rtl/food_placer.sv
// Food placement engine: random index -> free grid cell -> (x, y), with linear probing.
// Optional FOOD_PLACER_STATS_EN adds probe_count (occupied probes of the last placement).
module food_placer #(
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int MAX_PROBES = 4800
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [13:0] rand_num,
  input  logic        place_req,
  output logic [13:0] occ_addr,
  output logic        occ_rd,
  input  logic        occ_data,
  output logic [13:0] food_idx,
  output logic [7:0]  food_x,
  output logic [7:0]  food_y,
  output logic        busy,
  output logic        done,
  output logic        fail
`ifdef FOOD_PLACER_STATS_EN
  , output logic [13:0] probe_count
`endif
);

  localparam logic [13:0] CELLS = 14'(GRID_W * GRID_H);
  localparam logic [13:0] LAST  = 14'(GRID_W * GRID_H - 1);
  localparam logic [13:0] W     = 14'(GRID_W);
  localparam logic [14:0] MAXP  = 15'(MAX_PROBES);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_READ, S_WAIT, S_CHECK, S_CONVERT, S_DONE, S_FAIL
  } state_t;

  state_t      r_state;
  logic [13:0] r_idx;
  logic [13:0] r_rem;
  logic [14:0] r_probes;
  logic [7:0]  r_ycnt;
`ifdef FOOD_PLACER_STATS_EN
  logic [13:0] r_probe_count;
  assign probe_count = r_probe_count;
`endif

  logic [14:0] w_probes_inc;
  logic [13:0] w_idx_next;
  assign w_probes_inc = r_probes + 15'd1;
  assign w_idx_next   = (r_idx == LAST) ? 14'd0 : r_idx + 14'd1;

  // Pulse outputs (occ_rd/done/fail) are set on entry to their state so they
  // line up with that state's cycle; food_* are loaded together with done.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_rem    <= '0;
      r_probes <= '0;
      r_ycnt   <= '0;
      occ_addr <= '0;
      occ_rd   <= 1'b0;
      food_idx <= '0;
      food_x   <= '0;
      food_y   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
`ifdef FOOD_PLACER_STATS_EN
      r_probe_count <= '0;
`endif
    end else begin
      occ_rd <= 1'b0;
      done   <= 1'b0;
      fail   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (place_req) begin
            r_idx    <= rand_num;
            r_probes <= '0;
            busy     <= 1'b1;
            r_state  <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (r_idx >= CELLS) begin
            r_idx <= r_idx - CELLS;
          end else begin
            occ_addr <= r_idx;
            occ_rd   <= 1'b1;
            r_state  <= S_READ;
          end
        end
        S_READ:  r_state <= S_WAIT;
        S_WAIT:  r_state <= S_CHECK;
        S_CHECK: begin
          if (!occ_data) begin
            r_rem   <= r_idx;
            r_ycnt  <= '0;
            r_state <= S_CONVERT;
          end else begin
            r_probes <= w_probes_inc;
            if (w_probes_inc == MAXP) begin
              fail    <= 1'b1;
              r_state <= S_FAIL;
`ifdef FOOD_PLACER_STATS_EN
              r_probe_count <= w_probes_inc[13:0];
`endif
            end else begin
              r_idx    <= w_idx_next;
              occ_addr <= w_idx_next;
              occ_rd   <= 1'b1;
              r_state  <= S_READ;
            end
          end
        end
        S_CONVERT: begin
          if (r_rem >= W) begin
            r_rem  <= r_rem - W;
            r_ycnt <= r_ycnt + 8'd1;
          end else begin
            food_idx <= r_idx;
            food_x   <= r_rem[7:0];
            food_y   <= r_ycnt;
            done     <= 1'b1;
            r_state  <= S_DONE;
`ifdef FOOD_PLACER_STATS_EN
            r_probe_count <= r_probes[13:0];
`endif
          end
        end
        S_DONE, S_FAIL: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: reference model predicts each placement's result and timing.
module tb_food_placer;
  localparam int GW    = 80;
  localparam int GH    = 60;
  localparam int CELLS = GW * GH;
  localparam int MAXP  = 4800;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] rand_num = '0;
  logic        place_req = 1'b0;
  logic [13:0] occ_addr;
  logic        occ_rd;
  logic        occ_data = 1'b0;
  logic [13:0] food_idx;
  logic [7:0]  food_x, food_y;
  logic        busy, done, fail;
`ifdef FOOD_PLACER_STATS_EN
  logic [13:0] probe_count;
`endif

  food_placer #(.GRID_W(GW), .GRID_H(GH), .MAX_PROBES(MAXP)) dut (
    .clock(clock), .resetn(resetn), .rand_num(rand_num), .place_req(place_req),
    .occ_addr(occ_addr), .occ_rd(occ_rd), .occ_data(occ_data),
    .food_idx(food_idx), .food_x(food_x), .food_y(food_y),
    .busy(busy), .done(done), .fail(fail)
`ifdef FOOD_PLACER_STATS_EN
    , .probe_count(probe_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_fail;
    int idx, x, y, cyc, probes;
  } exp_t;

  exp_t sb[$];
  bit   mem [CELLS];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   m_fidx = 0, m_fx = 0, m_fy = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Occupancy RAM: registered read, data holds until the next read.
  always @(posedge clock) begin
    if (occ_rd) begin
      chk("occ_addr_range", (int'(occ_addr) < CELLS) ? 1 : 0, 1);
      occ_data <= (int'(occ_addr) < CELLS) ? mem[occ_addr] : 1'b1;
    end
  end

  // Reference: modular reduction, linear scan with wrap, divide/modulo for (x, y).
  function automatic exp_t model(input int r, input int issue);
    exp_t e;
    int i, red, occ;
    bit found;
    i = r % CELLS; red = r / CELLS; occ = 0; found = 0;
    while (!found && occ < MAXP) begin
      if (!mem[i]) found = 1;
      else begin occ++; i = (i + 1) % CELLS; end
    end
    e.probes = occ;
    if (found) begin
      e.is_fail = 0; e.idx = i; e.x = i % GW; e.y = i / GW;
      e.cyc = issue + red + 6 + e.y + 3 * occ;
      m_fidx = e.idx; m_fx = e.x; m_fy = e.y;
    end else begin
      e.is_fail = 1; e.idx = m_fidx; e.x = m_fx; e.y = m_fy;
      e.cyc = issue + red + 2 + 3 * occ;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      if (done && fail) chk("done_and_fail", 1, 0);
      if (done || fail) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("kind_fail", int'(fail), int'(e.is_fail));
          chk("cycle", cyc, e.cyc);
          chk("food_idx", int'(food_idx), e.idx);
          chk("food_x", int'(food_x), e.x);
          chk("food_y", int'(food_y), e.y);
`ifdef FOOD_PLACER_STATS_EN
          chk("probe_count", int'(probe_count), e.probes);
`endif
        end
      end
    end
  end

  task automatic fill(input int pct);
    for (int i = 0; i < CELLS; i++) mem[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic issue(input int r);
    exp_t e;
    rand_num  = 14'(r);
    place_req = 1'b1;
    e = model(r, cyc);
    sb.push_back(e);
    @(posedge clock); #1;
    place_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("timeout", (sb.size() != 0 || busy) ? 1 : 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_occ_rd"}, int'(occ_rd), 0);
    chk({tag, "_occ_addr"}, int'(occ_addr), 0);
    chk({tag, "_food_idx"}, int'(food_idx), 0);
    chk({tag, "_food_x"}, int'(food_x), 0);
    chk({tag, "_food_y"}, int'(food_y), 0);
  endtask

  initial begin
    exp_t e1, e2;
    int n;
    fill(0);
    #23;
    chk_all_zero("rst");
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Cell 0 free: done at cycle 6, busy over cycles 1..6, read strobe in cycle 2.
    issue(0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      chk($sformatf("busy_c%0d", k), int'(busy), (k <= 6) ? 1 : 0);
      if (k == 2) chk("occ_rd_c2", int'(occ_rd), 1);
    end
    wait_idle(100);

    // One out-of-range subtraction: 5000 -> 200 -> (40, 2).
    issue(5000);
    wait_idle(100);

    // Wrap from last cell to 0.
    mem[CELLS-1] = 1'b1;
    issue(CELLS - 1);
    wait_idle(100);

    // Completely occupied grid: fail after MAXP probes, food_* unchanged.
    fill(100);
    issue(17);
    wait_idle(20000);

    // Reset in the middle of CONVERT.
    fill(0);
    issue(4000);
    repeat (20) @(negedge clock);
    chk("busy_before_reset", int'(busy), 1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("midrst");
    sb.delete();
    m_fidx = 0; m_fx = 0; m_fy = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    issue(1234);
    wait_idle(200);

    // place_req held: second acceptance in the cycle after DONE, then exactly two placements.
    fill(20);
    @(negedge clock);
    n = $urandom_range(0, 16383);
    e1 = model(n, cyc);
    e2 = model(n, e1.cyc + 1);
    sb.push_back(e1);
    sb.push_back(e2);
    rand_num  = 14'(n);
    place_req = 1'b1;
    n = 0;
    while (!done && n < 2000) begin @(negedge clock); n++; end
    @(posedge clock);
    @(posedge clock); #1;
    place_req = 1'b0;
    wait_idle(2000);
    repeat (10) @(negedge clock);

    // Randomized occupancy and indices.
    for (int t = 0; t < 25; t++) begin
      fill($urandom_range(0, 95));
      if (t % 5 == 0) mem[$urandom_range(0, CELLS - 1)] = 1'b0;
      issue($urandom_range(0, 16383));
      wait_idle(20000);
    end

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
